// File: rtl/imem_loader.sv
// imem_loader
// Receives a program image as a byte stream and writes it, one word at a
// time, into the instruction memory write port. The core is held in reset
// until the whole image is in memory.
//
// Stream format: 4-byte little-endian word count LEN, then LEN words of
// 4 little-endian bytes each.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   in_valid  byte source has a byte on in_data
//   in_data   stream byte
//   in_ready  loader accepts a byte this cycle
//   we        imem write enable, one-cycle pulse per word
//   waddr     imem word address (holds last value when we=0)
//   wdata     imem write data (holds last value when we=0)
//   core_rst  reset to the core, low only once loading is complete
//   done      image fully written (sticky until rst)
//   err       header length illegal (sticky until rst)
module imem_loader #(
  parameter int DATA_WIDTH      = 32,
  parameter int IMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic                       we,
  output logic [IMEM_ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0]      wdata,
  output logic                       core_rst,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned MAX_WORDS = 2 ** IMEM_ADDR_WIDTH;
  localparam logic [IMEM_ADDR_WIDTH:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_t;

  state_t                     state_q;
  logic [1:0]                 byteCnt_q;
  // One bit wider than the address so a count of MAX_WORDS is representable.
  logic [IMEM_ADDR_WIDTH:0]   wordCnt_q;
  logic [IMEM_ADDR_WIDTH:0]   len_q;
  logic [DATA_WIDTH-1:0]      asm_q;
  logic                       we_q;
  logic [IMEM_ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic                       coreRst_q;
  logic                       done_q;
  logic                       err_q;

  logic                       accept;
  logic [DATA_WIDTH-1:0]      asm_d;
  logic [IMEM_ADDR_WIDTH:0]   wordCntInc;

  // in_ready is combinational so that a byte is never accepted during rst
  // and never accepted in the cycle the FSM leaves HDR/LOAD.
  assign in_ready = ~rst & ((state_q == S_HDR) | (state_q == S_LOAD));
  assign accept   = in_valid & in_ready;

  // asm_d is the assembly register with the incoming byte merged into its
  // little-endian lane; when byteCnt_q is 3 it is the completed word.
  always_comb begin
    asm_d = asm_q;
    asm_d[{byteCnt_q, 3'b000} +: 8] = in_data;
    wordCntInc = wordCnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HDR;
      byteCnt_q <= '0;
      wordCnt_q <= '0;
      len_q     <= '0;
      asm_q     <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      coreRst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_HDR: begin
          if (accept) begin
            asm_q     <= asm_d;
            byteCnt_q <= byteCnt_q + 2'd1;
            if (byteCnt_q == 2'd3) begin
              wordCnt_q <= '0;
              if (asm_d[31:0] == 32'd0) begin
                // Empty image: nothing to write, release the core now.
                state_q   <= S_DONE;
                done_q    <= 1'b1;
                coreRst_q <= 1'b0;
              end else if (asm_d[31:0] > MAX_WORDS) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
              end else begin
                state_q <= S_LOAD;
                len_q   <= asm_d[IMEM_ADDR_WIDTH:0];
              end
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            asm_q     <= asm_d;
            byteCnt_q <= byteCnt_q + 2'd1;
            if (byteCnt_q == 2'd3) begin
              we_q      <= 1'b1;
              waddr_q   <= wordCnt_q[IMEM_ADDR_WIDTH-1:0];
              wdata_q   <= asm_d;
              wordCnt_q <= wordCntInc;
              // FLUSH carries the final write pulse before DONE.
              if (wordCntInc == len_q) begin
                state_q <= S_FLUSH;
              end
            end
          end
        end
        S_FLUSH: begin
          state_q   <= S_DONE;
          done_q    <= 1'b1;
          coreRst_q <= 1'b0;
        end
        S_DONE, S_ERR: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= S_HDR;
        end
      endcase
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign core_rst = coreRst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed self-checking bench for imem_loader. Inputs are driven on the
// falling edge, outputs sampled on the falling edge, and every write pulse
// is captured by a monitor for later comparison against expected words.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lastAcceptCyc = 0;

  logic [9:0]  wAddrQ[$];
  logic [31:0] wDataQ[$];

  imem_loader #(
    .DATA_WIDTH(32),
    .IMEM_ADDR_WIDTH(10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .core_rst(core_rst),
    .done    (done),
    .err     (err)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to relate write pulses to byte acceptance.
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every imem write seen on the falling edge.
  always @(negedge clk) begin
    if (we) begin
      wAddrQ.push_back(waddr);
      wDataQ.push_back(wdata);
    end
  end

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  // Called and returns on a falling edge; in_valid is left high.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checkOutput("readyTimeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      lastAcceptCyc = cyc;
    end
  endtask

  task automatic sendWord(input logic [31:0] w, input int gap);
    applyStimulus(w[7:0], gap);
    applyStimulus(w[15:8], gap);
    applyStimulus(w[23:16], gap);
    applyStimulus(w[31:24], gap);
  endtask

  // Reset for two cycles, checking the reset output values each cycle.
  task automatic doReset(input string tag);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput({tag, ".ready"}, {31'd0, in_ready}, 32'd0);
      checkOutput({tag, ".we"}, {31'd0, we}, 32'd0);
      checkOutput({tag, ".waddr"}, {22'd0, waddr}, 32'd0);
      checkOutput({tag, ".wdata"}, wdata, 32'd0);
      checkOutput({tag, ".coreRst"}, {31'd0, core_rst}, 32'd1);
      checkOutput({tag, ".done"}, {31'd0, done}, 32'd0);
      checkOutput({tag, ".err"}, {31'd0, err}, 32'd0);
    end
    wAddrQ.delete();
    wDataQ.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] bigWord(input int i);
    return 32'h5A00_0000 + (i << 12) + i;
  endfunction

  logic [31:0] prog[3];

  initial begin
    prog[0] = 32'd2;
    prog[1] = 32'h0050_0513;
    prog[2] = 32'h00A0_0593;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);

    // Ordered stream with in_valid held high.
    doReset("rst1");
    checkOutput("idle.ready", {31'd0, in_ready}, 32'd1);
    sendWord(prog[0], 0);
    checkOutput("hdr.we", {31'd0, we}, 32'd0);
    sendWord(prog[1], 0);
    checkOutput("w0.we", {31'd0, we}, 32'd1);
    checkOutput("w0.waddr", {22'd0, waddr}, 32'd0);
    checkOutput("w0.wdata", wdata, 32'h0050_0513);
    sendWord(prog[2], 0);
    checkOutput("w1.we", {31'd0, we}, 32'd1);
    checkOutput("w1.waddr", {22'd0, waddr}, 32'd1);
    checkOutput("w1.wdata", wdata, 32'h00A0_0593);
    checkOutput("flush.ready", {31'd0, in_ready}, 32'd0);
    checkOutput("flush.done", {31'd0, done}, 32'd0);
    checkOutput("flush.coreRst", {31'd0, core_rst}, 32'd1);
    @(negedge clk);
    checkOutput("fin.done", {31'd0, done}, 32'd1);
    checkOutput("fin.coreRst", {31'd0, core_rst}, 32'd0);
    checkOutput("fin.we", {31'd0, we}, 32'd0);
    checkOutput("fin.ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("fin.writes", wAddrQ.size(), 32'd2);
    checkOutput("fin.holdAddr", {22'd0, waddr}, 32'd1);
    checkOutput("fin.holdData", wdata, 32'h00A0_0593);

    // Same stream with random gaps; in_valid stays high through FLUSH/DONE.
    doReset("rst2");
    for (int w = 0; w < 3; w++) sendWord(prog[w], $urandom_range(0, 3));
    in_data = 8'hEE;
    repeat (6) @(negedge clk);
    checkOutput("gap.writes", wAddrQ.size(), 32'd2);
    if (wAddrQ.size() == 2) begin
      checkOutput("gap.a0", {22'd0, wAddrQ[0]}, 32'd0);
      checkOutput("gap.d0", wDataQ[0], 32'h0050_0513);
      checkOutput("gap.a1", {22'd0, wAddrQ[1]}, 32'd1);
      checkOutput("gap.d1", wDataQ[1], 32'h00A0_0593);
    end
    checkOutput("gap.done", {31'd0, done}, 32'd1);
    checkOutput("gap.coreRst", {31'd0, core_rst}, 32'd0);
    checkOutput("gap.err", {31'd0, err}, 32'd0);

    // Empty image: done in the cycle after the fourth header byte.
    doReset("rst3");
    sendWord(32'd0, 0);
    checkOutput("len0.done", {31'd0, done}, 32'd1);
    checkOutput("len0.coreRst", {31'd0, core_rst}, 32'd0);
    checkOutput("len0.ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("len0.writes", wAddrQ.size(), 32'd0);

    // Oversized header: sticky error with the core held in reset.
    doReset("rst4");
    sendWord(32'h0000_0401, 0);
    checkOutput("big.err", {31'd0, err}, 32'd1);
    for (int i = 0; i < 22; i++) begin
      in_data = 8'(i);
      @(negedge clk);
    end
    checkOutput("big.errHeld", {31'd0, err}, 32'd1);
    checkOutput("big.ready", {31'd0, in_ready}, 32'd0);
    checkOutput("big.coreRst", {31'd0, core_rst}, 32'd1);
    checkOutput("big.done", {31'd0, done}, 32'd0);
    checkOutput("big.writes", wAddrQ.size(), 32'd0);

    // Maximum legal image fills every address.
    doReset("rst5");
    sendWord(32'd1024, 0);
    for (int i = 0; i < 1024; i++) sendWord(bigWord(i), 0);
    @(negedge clk);
    checkOutput("max.writes", wAddrQ.size(), 32'd1024);
    if (wAddrQ.size() == 1024) begin
      for (int i = 0; i < 1024; i++) begin
        checkOutput("max.addr", {22'd0, wAddrQ[i]}, i);
        checkOutput("max.data", wDataQ[i], bigWord(i));
      end
    end
    checkOutput("max.lastAddr", {22'd0, waddr}, 32'h3FF);
    checkOutput("max.done", {31'd0, done}, 32'd1);
    checkOutput("max.coreRst", {31'd0, core_rst}, 32'd0);

    // Reset part-way into a word, then reload the full stream.
    doReset("rst6");
    sendWord(prog[0], 0);
    applyStimulus(8'h13, 0);
    applyStimulus(8'h05, 0);
    doReset("midRst");
    for (int w = 0; w < 3; w++) sendWord(prog[w], 0);
    @(negedge clk);
    checkOutput("mid.writes", wAddrQ.size(), 32'd2);
    if (wAddrQ.size() == 2) begin
      checkOutput("mid.a0", {22'd0, wAddrQ[0]}, 32'd0);
      checkOutput("mid.d0", wDataQ[0], 32'h0050_0513);
      checkOutput("mid.a1", {22'd0, wAddrQ[1]}, 32'd1);
      checkOutput("mid.d1", wDataQ[1], 32'h00A0_0593);
    end
    checkOutput("mid.done", {31'd0, done}, 32'd1);

    in_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
